// File: rtl/spram_uart_dual_buffer.sv
// Ping-pong frame buffer: bytes framed by vsync_in fill one of two SPRAM-style banks
// while the other bank is replayed over an 8N1 UART, bracketed by vsync_out.
module spram_uart_dual_buffer #(
    parameter int CLKS_PER_BIT = 20,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    input  logic       vsync_in,
    output logic       uart_tx,
    output logic       vsync_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]       CLK_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] BANK_FREE    = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_READY   = 2'd2;
    localparam logic [1:0] BANK_SENDING = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_FETCH = 2'd1;
    localparam logic [1:0] TX_SEND  = 2'd2;
    localparam logic [1:0] TX_DONE  = 2'd3;

    // Fill side state
    logic                  vsync_q;
    logic [1:0]            bank_state [0:1];
    logic [ADDR_WIDTH:0]   bank_count [0:1];
    logic                  fill_active;
    logic                  fill_bank;
    logic                  last_fill;
    logic                  older_ready;

    // Transmit side state
    logic [1:0]            tx_state;
    logic                  tx_bank;
    logic                  fetch_wait;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [CW-1:0]         clk_cnt;
    logic [3:0]            bit_idx;
    logic [9:0]            frame_sr;

    // Combinational decisions
    logic                  vs_rise;
    logic                  vs_fall;
    logic [1:0]            bank_free;
    logic [1:0]            bank_ready;
    logic                  fill_pick;
    logic                  start_fill;
    logic                  tx_pick;
    logic                  tx_start;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   rd_next;

    // RAM ports
    logic [1:0]            ram_wren;
    logic [ADDR_WIDTH-1:0] ram_addr [0:1];
    logic [15:0]           ram_wdata;
    logic [15:0]           ram_rdata [0:1];
    logic                  unused_rdata_hi;

    assign vs_rise   = vsync_in & ~vsync_q;
    assign vs_fall   = ~vsync_in & vsync_q;
    assign ram_wdata = {8'h00, data_in};
    assign rd_next   = rd_ptr + 1'b1;
    assign unused_rdata_hi = ^{ram_rdata[0][15:8], ram_rdata[1][15:8]};

    // A bank being released by the transmitter this cycle counts as free for a new frame.
    always_comb begin
        bank_free  = 2'b00;
        bank_ready = 2'b00;
        for (int b = 0; b < 2; b++) begin
            bank_free[b]  = (bank_state[b] == BANK_FREE) ||
                            (tx_state == TX_DONE && tx_bank == 1'(b));
            bank_ready[b] = (bank_state[b] == BANK_READY);
        end
        fill_pick  = (&bank_free) ? ~last_fill : bank_free[1];
        start_fill = vs_rise && (|bank_free);
        tx_pick    = (&bank_ready) ? older_ready : bank_ready[1];
        tx_start   = (tx_state == TX_IDLE) && (|bank_ready);
        fill_count = bank_count[fill_bank];
        wr_en      = data_in_valid && vsync_in && fill_active && (fill_count < COUNT_FULL);
    end

    // The filling bank is addressed by its count, the sending bank by the read pointer.
    always_comb begin
        ram_wren = 2'b00;
        for (int b = 0; b < 2; b++) begin
            ram_wren[b] = wr_en && (fill_bank == 1'(b));
            ram_addr[b] = (fill_active && fill_bank == 1'(b)) ? fill_count[ADDR_WIDTH-1:0]
                                                              : rd_ptr[ADDR_WIDTH-1:0];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic [15:0] mem [0:DEPTH-1];
        logic [15:0] rdata;

        always_ff @(posedge clock) begin
            if (ram_wren[g]) mem[ram_addr[g]] <= ram_wdata;
            rdata <= mem[ram_addr[g]];
        end

        assign ram_rdata[g] = rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q     <= 1'b0;
            fill_active <= 1'b0;
            fill_bank   <= 1'b0;
            last_fill   <= 1'b1;
            older_ready <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_FREE;
                bank_count[b] <= '0;
            end
        end else begin
            vsync_q <= vsync_in;
            if (tx_state == TX_DONE) bank_state[tx_bank] <= BANK_FREE;
            if (tx_start) bank_state[tx_pick] <= BANK_SENDING;
            if (start_fill) begin
                bank_state[fill_pick] <= BANK_FILLING;
                bank_count[fill_pick] <= '0;
                fill_active           <= 1'b1;
                fill_bank             <= fill_pick;
                last_fill             <= fill_pick;
            end
            if (vs_fall && fill_active) begin
                fill_active <= 1'b0;
                if (fill_count != '0) begin
                    bank_state[fill_bank] <= BANK_READY;
                    older_ready <= bank_ready[~fill_bank] ? ~fill_bank : fill_bank;
                end else begin
                    bank_state[fill_bank] <= BANK_FREE;
                end
            end
            if (wr_en) bank_count[fill_bank] <= fill_count + 1'b1;
        end
    end

    // FETCH spends one cycle presenting the address and one capturing the RAM output.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_bank    <= 1'b0;
            fetch_wait <= 1'b0;
            rd_ptr     <= '0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            frame_sr   <= '1;
            uart_tx    <= 1'b1;
            vsync_out  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_bank    <= tx_pick;
                        rd_ptr     <= '0;
                        fetch_wait <= 1'b1;
                        vsync_out  <= 1'b1;
                        tx_state   <= TX_FETCH;
                    end
                end
                TX_FETCH: begin
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else begin
                        frame_sr <= {1'b1, ram_rdata[tx_bank][7:0], 1'b0};
                        uart_tx  <= 1'b0;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (clk_cnt == CLK_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            rd_ptr <= rd_next;
                            if (rd_next == bank_count[tx_bank]) begin
                                tx_state <= TX_DONE;
                            end else begin
                                fetch_wait <= 1'b1;
                                tx_state   <= TX_FETCH;
                            end
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            uart_tx  <= frame_sr[1];
                            frame_sr <= {1'b1, frame_sr[9:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_DONE: begin
                    vsync_out <= 1'b0;
                    tx_state  <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_uart_dual_buffer.sv
// Bench for spram_uart_dual_buffer: frame table, directed ping-pong/drop/reset sequences,
// and random frames checked by a UART decoder against queues of expected bytes and bursts.
module tb_spram_uart_dual_buffer;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       vsync_in;
    logic       uart_tx;
    logic       vsync_out;

    always #5 clock = ~clock;

    spram_uart_dual_buffer #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .vsync_in      (vsync_in),
        .uart_tx       (uart_tx),
        .vsync_out     (vsync_out)
    );

    // Scoreboard
    logic [7:0] exp_q[$];
    int         exp_len_q[$];
    logic [7:0] frame_bytes[$];
    int n_cmp = 0;
    int n_err = 0;
    int rx_bytes = 0;
    int burst_bytes = 0;
    int bursts_started = 0;
    int bursts_done = 0;
    int epoch = 0;

    typedef struct {
        int n_bytes;
        int max_gap;
        int exp_sent;
        int exp_bursts;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic got_byte(input logic [7:0] b, input logic ok_start, input logic ok_stop,
                            input logic vs);
        rx_bytes++;
        burst_bytes++;
        check("start_bit", ok_start, 1'b1);
        check("stop_bit", ok_stop, 1'b1);
        check("vsync_out_during_byte", vs, 1'b1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_byte: got unexpected byte %02h, required none", b);
        end else begin
            check("rx_byte", b, exp_q.pop_front());
        end
    endtask

    // UART decoder: samples each bit near its middle on the falling clock edge.
    initial begin : uart_mon
        int         ep;
        logic [7:0] b;
        logic       ok_start, ok_stop, vs;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && uart_tx === 1'b0) begin
                ep = epoch;
                repeat (CPB / 2) @(negedge clock);
                ok_start = (uart_tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clock);
                ok_stop = (uart_tx === 1'b1);
                vs      = vsync_out;
                if (ep == epoch) got_byte(b, ok_start, ok_stop, vs);
            end
        end
    end

    // Each vsync_out high interval must carry exactly one expected frame.
    initial begin : burst_mon
        logic prev;
        int   bep;
        prev = 1'b0;
        bep  = 0;
        forever begin
            @(negedge clock);
            if (vsync_out === 1'b1 && !prev) begin
                bursts_started++;
                burst_bytes = 0;
                bep = epoch;
            end
            if (vsync_out !== 1'b1 && prev && bep == epoch) begin
                bursts_done++;
                if (exp_len_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL burst_len: got burst of %0d bytes, required none", burst_bytes);
                end else begin
                    check("burst_len", burst_bytes, exp_len_q.pop_front());
                end
            end
            prev = (vsync_out === 1'b1);
        end
    end

    task automatic drive_frame(input int n, input int max_gap, input bit rnd_data,
                               input logic [7:0] base);
        logic [7:0] b;
        frame_bytes.delete();
        @(negedge clock);
        vsync_in = 1'b1;
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            b = rnd_data ? 8'($urandom) : base + 8'(i);
            data_in       = b;
            data_in_valid = 1'b1;
            frame_bytes.push_back(b);
            @(negedge clock);
            data_in_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clock);
        end
        vsync_in      = 1'b0;
        data_in       = 8'hAA;
        data_in_valid = 1'b1;
        @(negedge clock);
        data_in_valid = 1'b0;
    endtask

    task automatic push_expected(input int n_keep);
        for (int i = 0; i < n_keep; i++) exp_q.push_back(frame_bytes[i]);
        if (n_keep > 0) exp_len_q.push_back(n_keep);
    endtask

    task automatic wait_bursts(input int target, input int budget);
        int k;
        k = 0;
        while (bursts_done < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        check("bursts_completed", bursts_done, target);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        vec_t vecs[5];
        int   r0, b0, d0, n, k;

        vecs[0] = '{3, 0, 3, 1};
        vecs[1] = '{0, 0, 0, 0};
        vecs[2] = '{20, 0, 16, 1};
        vecs[3] = '{16, 2, 16, 1};
        vecs[4] = '{1, 3, 1, 1};

        reset         = 1'b1;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        vsync_in      = 1'b0;
        repeat (4) @(negedge clock);
        check("reset_uart_tx", uart_tx, 1'b1);
        check("reset_vsync_out", vsync_out, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_uart_tx", uart_tx, 1'b1);
        check("idle_vsync_out", vsync_out, 1'b0);

        // Single frames in isolation, counting pattern from 00
        for (int i = 0; i < 5; i++) begin
            r0 = rx_bytes;
            b0 = bursts_started;
            d0 = bursts_done;
            drive_frame(vecs[i].n_bytes, vecs[i].max_gap, 1'b0, 8'h00);
            push_expected(vecs[i].exp_sent);
            wait_bursts(d0 + vecs[i].exp_bursts, (vecs[i].n_bytes + 2) * 50 + 200);
            repeat (60) @(negedge clock);
            check("vec_bytes_sent", rx_bytes - r0, vecs[i].exp_sent);
            check("vec_bursts", bursts_started - b0, vecs[i].exp_bursts);
            check("vec_end_uart_tx", uart_tx, 1'b1);
            check("vec_end_vsync_out", vsync_out, 1'b0);
        end

        // A then B: B fills while A transmits
        r0 = rx_bytes;
        d0 = bursts_done;
        drive_frame(5, 0, 1'b1, 8'h00);
        push_expected(5);
        drive_frame(5, 0, 1'b1, 8'h00);
        push_expected(5);
        wait_bursts(d0 + 2, 1000);
        check("ab_bytes_sent", rx_bytes - r0, 10);

        // A, B, then C while A sends and B waits: C must vanish
        r0 = rx_bytes;
        b0 = bursts_started;
        d0 = bursts_done;
        drive_frame(5, 0, 1'b1, 8'h00);
        push_expected(5);
        drive_frame(5, 0, 1'b1, 8'h00);
        push_expected(5);
        drive_frame(5, 0, 1'b1, 8'h00);
        wait_bursts(d0 + 2, 1000);
        repeat (300) @(negedge clock);
        check("abc_bytes_sent", rx_bytes - r0, 10);
        check("abc_bursts", bursts_started - b0, 2);

        // Reset in the middle of byte 00
        b0 = bursts_started;
        drive_frame(4, 0, 1'b0, 8'h00);
        push_expected(4);
        k = 0;
        while (bursts_started == b0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("reset_test_burst_started", bursts_started - b0, 1);
        repeat (15) @(negedge clock);
        check("mid_byte_uart_tx", uart_tx, 1'b0);
        epoch++;
        exp_q.delete();
        exp_len_q.delete();
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_uart_tx", uart_tx, 1'b1);
        check("mid_reset_vsync_out", vsync_out, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clock);
        r0 = rx_bytes;
        d0 = bursts_done;
        drive_frame(6, 1, 1'b1, 8'h00);
        push_expected(6);
        wait_bursts(d0 + 1, 600);
        check("post_reset_bytes_sent", rx_bytes - r0, 6);

        // Random frames; each starts once a bank is known to be free
        r0 = rx_bytes;
        d0 = bursts_done;
        k  = 0;
        for (int f = 0; f < 10; f++) begin
            int w;
            w = 0;
            while (exp_len_q.size() >= 2 && w < 2000) begin
                @(negedge clock);
                w++;
            end
            check("rand_bank_freed", (exp_len_q.size() < 2) ? 1 : 0, 1);
            repeat (3 * CPB) @(negedge clock);
            n = $urandom_range(24, 1);
            drive_frame(n, $urandom_range(3, 0), 1'b1, 8'h00);
            push_expected((n > DEPTH) ? DEPTH : n);
            k += (n > DEPTH) ? DEPTH : n;
        end
        wait_bursts(d0 + 10, 12000);
        check("rand_bytes_sent", rx_bytes - r0, k);
        check("rand_queue_drained", exp_q.size(), 0);

        repeat (20) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spram_uart_dual_buffer.md
Name: spram_uart_dual_buffer

Overview:
- Ping-pong frame buffer between a byte-stream source (e.g. JPEG encoder output) and a UART transmitter.
- Bytes arriving while vsync_in is high are written into one of two single-port RAM banks (iCE40 SPRAM style, 16-bit words).
- At frame end that bank is queued for transmission. Its bytes are then shifted out over 8N1 UART while the other bank fills with the next frame.
- vsync_out frames each transmitted burst for the downstream receiver.

Parameters:
- CLKS_PER_BIT, 20: clock cycles per UART bit (500 kbaud at 10 MHz). Minimum 2.
- ADDR_WIDTH, 14: word-address width of each bank. DEPTH = 2^ADDR_WIDTH bytes per bank.

Ports:
- clock  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  input byte.
- data_in_valid  input  1  data_in is valid this cycle (single-cycle strobe, no backpressure).
- vsync_in  input  1  high for the duration of an input frame.
- uart_tx  output  1  UART serial output, idle high.
- vsync_out  output  1  high while a buffered frame is being transmitted.

Behaviour:
- Reset values:
  - uart_tx=1, vsync_out=0.
  - Both banks empty and not ready; byte counts 0; fill bank = none; transmitter idle.
  - Edge-detect register for vsync_in = 0.
- Storage:
  - Per bank: one RAM of DEPTH x 16 bits with per-bank address, wren, data_in and data_out. Each byte occupies one word, stored in bits [7:0] with bits [15:8] = 0.
  - Read latency is 1 cycle: the address presented in cycle N gives data_out in cycle N+1.
  - Each bank has a byte count of ADDR_WIDTH+1 bits.
- Bank state: each bank is FREE, FILLING, READY or SENDING.
- Frame start (vsync_in rises, detected against the registered previous value):
  - Choose a FREE bank; if both are FREE, take the bank not used last. Clear its count and mark it FILLING.
  - If no bank is FREE, the whole frame is dropped: all its bytes are ignored.
- Writing a byte: accepted when data_in_valid=1, vsync_in=1, a bank is FILLING and count < DEPTH.
  - The byte is written at address = count, and count increments in the same cycle.
  - Bytes beyond DEPTH are discarded; the count saturates at DEPTH.
  - Bytes with vsync_in=0 are ignored.
- Frame end (vsync_in falls):
  - The FILLING bank becomes READY if count > 0; otherwise it becomes FREE.
  - Fill bank = none.
- Transmitter FSM: IDLE -> FETCH -> SEND -> (FETCH or DONE) -> IDLE.
  - IDLE: if a bank is READY, mark it SENDING (if both are READY, take the one completed first), set the read pointer to 0, and go to FETCH. vsync_out is set to 1 on that IDLE->FETCH transition.
  - FETCH: drive the read address for 1 cycle and capture the byte on the following cycle.
  - SEND: shift out the 8N1 frame: start bit 0, data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles. There is no gap between bytes beyond the fetch latency.
  - After the stop bit of byte index count-1, go to DONE. DONE sets vsync_out=0, marks the bank FREE, and returns to IDLE.
- Simultaneity:
  - A bank leaving SENDING->FREE in the same cycle as a vsync_in rise may be chosen as the fill bank.
  - A bank becoming READY in the same cycle the transmitter is IDLE is started on the next cycle.
- Throughput: up to one frame stored while another is sent. A frame arriving while one bank is READY and the other is SENDING is dropped.
- Reset mid-operation: everything returns to the reset state immediately. uart_tx goes high (a partial byte may be truncated), vsync_out goes low, and buffered data is discarded.

Test Plan:
- Single frame of bytes 00,01,02 with vsync_in pulses, CLKS_PER_BIT=20 -> vsync_out rises after the frame end. uart_tx carries 3 frames of 200 cycles each, decoding to 00,01,02. vsync_out falls after the last stop bit.
- 10 frames, each with 100..227 bytes in the counting pattern from 00, random 0..255-cycle gaps between bytes, 100000-cycle frame period -> every frame is received intact and in order. Each frame has one vsync_out high interval, and no frames are dropped.
- Back-to-back short frames A (5 bytes) then B (5 bytes), where B fills while A transmits -> the two banks alternate and A then B are output. vsync_out goes low for at least 1 cycle between them.
- Third frame C arriving while A is SENDING and B is READY -> C is dropped entirely. Output is A then B only.
- Frame with 0 valid bytes -> no UART activity and vsync_out stays 0.
- With ADDR_WIDTH=4, send a 20-byte frame -> exactly 16 bytes (00..0F) are transmitted.
- Assert reset mid-byte -> the next cycle shows uart_tx=1 and vsync_out=0. A subsequent frame is transmitted correctly.
